// File: rtl/pipe_stage_hs_pkg.sv
// pipe_stage_hs_pkg: occupancy encodings and per-stage payload widths for pipeline-stage registers
package pipe_stage_hs_pkg;
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;
   localparam int IF_ID_W  = 64;
   localparam int ID_EX_W  = 128;
   localparam int EX_MEM_W = 96;
   localparam int MEM_WB_W = 96;
endpackage

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: handshaked pipeline-stage register with optional 2-entry skid buffer and flush
module pipe_stage_hs
   import pipe_stage_hs_pkg::*;
#(
   parameter int                DATA_W    = 96,
   parameter int                SKID      = 1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        occ_o
);
   logic [DATA_W-1:0] main_q, main_d;
   assign data_o = main_q;
   generate
      if (SKID != 0) begin : g_skid
         occ_t              occ_q, occ_d;
         logic [DATA_W-1:0] skid_q, skid_d;
         logic              accept, emit;
         assign ready_o = occ_q != OCC_FULL;
         assign valid_o = occ_q != OCC_EMPTY;
         assign occ_o   = occ_q;
         assign accept  = valid_i & ready_o;
         assign emit    = valid_o & ready_i;
         // occupancy FSM: main holds the head, skid catches the one extra beat under back-pressure
         always_comb begin
            occ_d  = occ_q;
            main_d = main_q;
            skid_d = skid_q;
            if (flush_i)
               occ_d = OCC_EMPTY;
            else
               case (occ_q)
                  OCC_EMPTY: if (accept) begin
                     occ_d  = OCC_ONE;
                     main_d = data_i;
                  end
                  OCC_ONE: if (accept && emit)
                     main_d = data_i;
                  else if (accept) begin
                     occ_d  = OCC_FULL;
                     skid_d = data_i;
                  end else if (emit)
                     occ_d = OCC_EMPTY;
                  OCC_FULL: if (emit) begin
                     occ_d  = OCC_ONE;
                     main_d = skid_q;
                  end
                  default: occ_d = OCC_EMPTY;
               endcase
         end
         // state and payload registers; reset alone restores RESET_VAL
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               occ_q  <= OCC_EMPTY;
               main_q <= RESET_VAL;
               skid_q <= RESET_VAL;
            end else begin
               occ_q  <= occ_d;
               main_q <= main_d;
               skid_q <= skid_d;
            end
         end
      end else begin : g_single
         logic valid_q, valid_d, accept;
         assign ready_o = ready_i | ~valid_q;
         assign valid_o = valid_q;
         assign occ_o   = {1'b0, valid_q};
         assign accept  = valid_i & ready_o;
         // single register: refill on accept, drain on emit, flush drops any accept
         always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (flush_i)
               valid_d = 1'b0;
            else if (accept) begin
               valid_d = 1'b1;
               main_d  = data_i;
            end else if (valid_q && ready_i)
               valid_d = 1'b0;
         end
         // valid and payload registers
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               valid_q <= 1'b0;
               main_q  <= RESET_VAL;
            end else begin
               valid_q <= valid_d;
               main_q  <= main_d;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed checks plus scoreboard monitors for SKID=1 and SKID=0 builds
module tb_pipe_stage_hs;
   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic        vi, ri, vi0, ri0;
   logic [15:0] di, di0;
   logic        a_ro, a_vo, b_ro, b_vo;
   logic [15:0] a_do, b_do;
   logic [1:0]  a_occ, b_occ;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   always #5 clk = ~clk;

   pipe_stage_hs #(.DATA_W(16), .SKID(1), .RESET_VAL(16'h5A5A)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .valid_i(vi), .ready_o(a_ro),
      .data_i(di), .valid_o(a_vo), .ready_i(ri), .data_o(a_do), .occ_o(a_occ));

   pipe_stage_hs #(.DATA_W(16), .SKID(0), .RESET_VAL(16'h00FF)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .valid_i(vi0), .ready_o(b_ro),
      .data_i(di0), .valid_o(b_vo), .ready_i(ri0), .data_o(b_do), .occ_o(b_occ));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard for the skid build: accepted beats queued, emitted beats popped in order
   always @(negedge clk) begin
      if (!rst_n || flush)
         qa.delete();
      else begin
         if (a_vo && ri) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL sb_a: got %h expected nothing", a_do);
            end else begin
               logic [15:0] e;
               e = qa.pop_front();
               if (a_do !== e) begin
                  errors++;
                  $display("FAIL sb_a: got %h expected %h", a_do, e);
               end
            end
         end
         if (vi && a_ro) qa.push_back(di);
      end
   end

   // scoreboard for the single-register build
   always @(negedge clk) begin
      if (!rst_n || flush)
         qb.delete();
      else begin
         if (b_vo && ri0) begin
            checks++;
            if (qb.size() == 0) begin
               errors++;
               $display("FAIL sb_b: got %h expected nothing", b_do);
            end else begin
               logic [15:0] e;
               e = qb.pop_front();
               if (b_do !== e) begin
                  errors++;
                  $display("FAIL sb_b: got %h expected %h", b_do, e);
               end
            end
         end
         if (vi0 && b_ro) qb.push_back(di0);
      end
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; vi = 1'b1; di = 16'hABC; ri = 1'b0;
      vi0 = 1'b0; di0 = '0; ri0 = 1'b0;
      step(); step();
      chk("rst_valid", 16'(a_vo), 16'd0);
      chk("rst_data", a_do, 16'h5A5A);
      chk("rst_occ", 16'(a_occ), 16'd0);
      chk("rst_b_data", b_do, 16'h00FF);
      rst_n = 1'b1; vi = 1'b0;
      step();
      chk("rel_ready", 16'(a_ro), 16'd1);
      chk("rel_valid", 16'(a_vo), 16'd0);
      // streaming
      ri = 1'b1; vi = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         di = 16'(i);
         step();
         chk("stream_data", a_do, 16'(i));
         chk("stream_valid", 16'(a_vo), 16'd1);
         chk("stream_ready", 16'(a_ro), 16'd1);
      end
      vi = 1'b0;
      step();
      chk("stream_drain", 16'(a_vo), 16'd0);
      // back-pressure
      ri = 1'b0; vi = 1'b1; di = 16'hA;
      step();
      chk("bp_occ1", 16'(a_occ), 16'd1);
      di = 16'hB;
      step();
      chk("bp_occ2", 16'(a_occ), 16'd2);
      chk("bp_ready", 16'(a_ro), 16'd0);
      chk("bp_data", a_do, 16'hA);
      vi = 1'b0;
      step();
      chk("bp_hold_data", a_do, 16'hA);
      chk("bp_hold_valid", 16'(a_vo), 16'd1);
      ri = 1'b1;
      step();
      chk("bp_data_b", a_do, 16'hB);
      chk("bp_occ_1", 16'(a_occ), 16'd1);
      step();
      chk("bp_occ_0", 16'(a_occ), 16'd0);
      chk("bp_ready1", 16'(a_ro), 16'd1);
      // flush while full
      ri = 1'b0; vi = 1'b1; di = 16'hC;
      step();
      di = 16'hD;
      step();
      chk("fl_pre_occ", 16'(a_occ), 16'd2);
      flush = 1'b1; di = 16'hF;
      step();
      chk("fl_valid", 16'(a_vo), 16'd0);
      chk("fl_occ", 16'(a_occ), 16'd0);
      chk("fl_ready", 16'(a_ro), 16'd1);
      chk("fl_keep_data", a_do, 16'hC);
      flush = 1'b0; vi = 1'b0; ri = 1'b1;
      step(); step();
      chk("fl_no_emit", 16'(a_vo), 16'd0);
      // reset mid-stream
      ri = 1'b0; vi = 1'b1; di = 16'h11;
      step();
      di = 16'h12;
      step();
      chk("mr_pre_occ", 16'(a_occ), 16'd2);
      rst_n = 1'b0; vi = 1'b0;
      step();
      chk("mr_occ", 16'(a_occ), 16'd0);
      chk("mr_data", a_do, 16'h5A5A);
      chk("mr_valid", 16'(a_vo), 16'd0);
      rst_n = 1'b1; vi = 1'b1; di = 16'h5; ri = 1'b1;
      step();
      chk("mr_push", a_do, 16'h5);
      chk("mr_push_v", 16'(a_vo), 16'd1);
      vi = 1'b0;
      step();
      chk("mr_drain", 16'(a_vo), 16'd0);
      // mixed back-pressure: ordering checked by the scoreboard
      vi = 1'b1;
      for (int i = 0; i < 16; i++) begin
         di = 16'h20 + 16'(i);
         ri = (i % 3) != 0;
         step();
      end
      vi = 1'b0; ri = 1'b1;
      step(); step(); step();
      chk("mix_empty_occ", 16'(a_occ), 16'd0);
      chk("mix_sb_empty", 16'(qa.size()), 16'd0);
      // single-register build
      ri0 = 1'b0; vi0 = 1'b1; di0 = 16'h6;
      step();
      chk("s0_data", b_do, 16'h6);
      chk("s0_occ", 16'(b_occ), 16'd1);
      vi0 = 1'b0;
      step();
      chk("s0_ready_low", 16'(b_ro), 16'd0);
      chk("s0_hold", b_do, 16'h6);
      ri0 = 1'b1; vi0 = 1'b1; di0 = 16'h7;
      #1;
      chk("s0_ready_comb", 16'(b_ro), 16'd1);
      step();
      chk("s0_replace", b_do, 16'h7);
      chk("s0_valid", 16'(b_vo), 16'd1);
      vi0 = 1'b0;
      step();
      chk("s0_drain", 16'(b_vo), 16'd0);
      chk("s0_occ0", 16'(b_occ), 16'd0);
      chk("s0_sb_empty", 16'(qb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
